axicb_slv_switch: RTL and testbench

Single-master-to-N-slave router of the AXI crossbar, the counterpart of the master-side switch. Decodes each AW/AR address against per-slave ranges and forwards the request to one slave. Routes W beats in AW order and arbitrates B/R responses from all slaves back to the one master. Unmapped addresses are answered locally with DECERR.

---
 rtl/axicb_slv_switch_if.sv | 80 ++++++++
 rtl/axicb_slv_switch.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_axicb_slv_switch.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axicb_slv_switch_if.sv
// -----------------------------------------------------------------------------
// axicb_slv_switch_if
// Bundles every handshake/channel signal of the slave switch.
//   i_*  : the single upstream master port (AW, W, B, AR, R).
//   o_*  : the per-slave downstream ports. Slave k uses bit k of each vector
//          and slice k of each *ch vector.
// Modports:
//   slave  - view of the switch itself (it is the slave of the master port).
//   master - view of whatever drives the switch (master and downstream slaves).
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where valid and ready are both high. Once raised, valid and its payload hold
// until that transfer.
// -----------------------------------------------------------------------------
interface axicb_slv_switch_if #(
   parameter int SLV_NB = 4,
   parameter int AWCH_W = 32,
   parameter int WCH_W  = 8,
   parameter int BCH_W  = 10,
   parameter int ARCH_W = 32,
   parameter int RCH_W  = 18
);
   // master side
   logic                      i_awvalid;
   logic                      i_awready;
   logic [AWCH_W-1:0]         i_awch;
   logic                      i_wvalid;
   logic                      i_wready;
   logic                      i_wlast;
   logic [WCH_W-1:0]          i_wch;
   logic                      i_bvalid;
   logic                      i_bready;
   logic [BCH_W-1:0]          i_bch;
   logic                      i_arvalid;
   logic                      i_arready;
   logic [ARCH_W-1:0]         i_arch;
   logic                      i_rvalid;
   logic                      i_rready;
   logic                      i_rlast;
   logic [RCH_W-1:0]          i_rch;
   // slave side
   logic [SLV_NB-1:0]         o_awvalid;
   logic [SLV_NB-1:0]         o_awready;
   logic [SLV_NB*AWCH_W-1:0]  o_awch;
   logic [SLV_NB-1:0]         o_wvalid;
   logic [SLV_NB-1:0]         o_wready;
   logic [SLV_NB-1:0]         o_wlast;
   logic [SLV_NB*WCH_W-1:0]   o_wch;
   logic [SLV_NB-1:0]         o_bvalid;
   logic [SLV_NB-1:0]         o_bready;
   logic [SLV_NB*BCH_W-1:0]   o_bch;
   logic [SLV_NB-1:0]         o_arvalid;
   logic [SLV_NB-1:0]         o_arready;
   logic [SLV_NB*ARCH_W-1:0]  o_arch;
   logic [SLV_NB-1:0]         o_rvalid;
   logic [SLV_NB-1:0]         o_rready;
   logic [SLV_NB-1:0]         o_rlast;
   logic [SLV_NB*RCH_W-1:0]   o_rch;

   modport slave (
      input  i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, i_bready,
             i_arvalid, i_arch, i_rready,
      output i_awready, i_wready, i_bvalid, i_bch, i_arready,
             i_rvalid, i_rlast, i_rch,
      output o_awvalid, o_awch, o_wvalid, o_wlast, o_wch, o_bready,
             o_arvalid, o_arch, o_rready,
      input  o_awready, o_wready, o_bvalid, o_bch, o_arready,
             o_rvalid, o_rlast, o_rch
   );

   modport master (
      output i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, i_bready,
             i_arvalid, i_arch, i_rready,
      input  i_awready, i_wready, i_bvalid, i_bch, i_arready,
             i_rvalid, i_rlast, i_rch,
      input  o_awvalid, o_awch, o_wvalid, o_wlast, o_wch, o_bready,
             o_arvalid, o_arch, o_rready,
      output o_awready, o_wready, o_bvalid, o_bch, o_arready,
             o_rvalid, o_rlast, o_rch
   );
endinterface

// File: rtl/axicb_slv_switch.sv
// -----------------------------------------------------------------------------
// axicb_slv_switch
// One master to SLV_NB slaves router of the AXI crossbar.
//   - AW/AR addresses are decoded against inclusive per-slave ranges (lowest
//     index wins) and forwarded combinationally to one slave; unmapped
//     addresses go to a local error responder (source index SLV_NB).
//   - W beats follow AW order through a W-route FIFO of one-hot targets.
//   - B and R from all slaves plus the error responder are merged by
//     round-robin arbiters; R grants are held for a whole burst.
// Ports:
//   aclk             clock, all state on rising edge
//   arst             asynchronous active-high reset
//   bus              channel bundle (slave modport)
//   dbg_wr_state     error write FSM state (0 idle, 1 sink W, 2 send B)
//   dbg_rd_state     error read FSM state (0 idle, 1 send R)
//   dbg_wfifo_empty  W-route FIFO is empty
// -----------------------------------------------------------------------------
module axicb_slv_switch #(
   parameter int AXI_ADDR_W = 16,
   parameter int AXI_ID_W   = 8,
   parameter int AXI_DATA_W = 8,
   parameter int SLV_NB     = 4,
   parameter logic [AXI_ADDR_W-1:0] SLV0_START_ADDR = 'h0000,
   parameter logic [AXI_ADDR_W-1:0] SLV0_END_ADDR   = 'h0FFF,
   parameter logic [AXI_ADDR_W-1:0] SLV1_START_ADDR = 'h1000,
   parameter logic [AXI_ADDR_W-1:0] SLV1_END_ADDR   = 'h1FFF,
   parameter logic [AXI_ADDR_W-1:0] SLV2_START_ADDR = 'h2000,
   parameter logic [AXI_ADDR_W-1:0] SLV2_END_ADDR   = 'h2FFF,
   parameter logic [AXI_ADDR_W-1:0] SLV3_START_ADDR = 'h3000,
   parameter logic [AXI_ADDR_W-1:0] SLV3_END_ADDR   = 'h3FFF,
   parameter int WFIFO_DEPTH_LOG2 = 3,
   parameter int AWCH_W = AXI_ADDR_W + AXI_ID_W + 8,
   parameter int WCH_W  = AXI_DATA_W,
   parameter int BCH_W  = 2 + AXI_ID_W,
   parameter int ARCH_W = AXI_ADDR_W + AXI_ID_W + 8,
   parameter int RCH_W  = 2 + AXI_ID_W + AXI_DATA_W
) (
   input  logic                 aclk,
   input  logic                 arst,
   axicb_slv_switch_if.slave    bus,
   output logic [1:0]           dbg_wr_state,
   output logic                 dbg_rd_state,
   output logic                 dbg_wfifo_empty
);

   localparam int NSRC  = SLV_NB + 1;   // slaves plus the error responder
   localparam int ERR   = SLV_NB;
   localparam int PTR_W = $clog2(NSRC);
   localparam int DEPTH = 1 << WFIFO_DEPTH_LOG2;
   localparam int L     = WFIFO_DEPTH_LOG2;
   localparam int ID_LSB  = AXI_ADDR_W;
   localparam int LEN_LSB = AXI_ADDR_W + AXI_ID_W;

   localparam logic [AXI_ADDR_W-1:0] START_A [4] =
      '{SLV0_START_ADDR, SLV1_START_ADDR, SLV2_START_ADDR, SLV3_START_ADDR};
   localparam logic [AXI_ADDR_W-1:0] END_A [4] =
      '{SLV0_END_ADDR, SLV1_END_ADDR, SLV2_END_ADDR, SLV3_END_ADDR};

   typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_DATA = 2'd1, WR_RESP = 2'd2} wr_state_t;
   typedef enum logic       {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_t;

   // one-hot target, bit ERR set when no range matches
   function automatic logic [SLV_NB:0] decode(input logic [AXI_ADDR_W-1:0] addr);
      logic [SLV_NB:0] sel;
      logic            hit;
      sel = '0;
      hit = 1'b0;
      for (int k = 0; k < SLV_NB; k++) begin
         if (!hit && addr >= START_A[k] && addr <= END_A[k]) begin
            sel[k] = 1'b1;
            hit    = 1'b1;
         end
      end
      if (!hit) sel[ERR] = 1'b1;
      return sel;
   endfunction

   // first requester at or after ptr, wrapping
   function automatic logic [PTR_W-1:0] rr_pick(input logic [NSRC-1:0] req,
                                                input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] win;
      logic             found;
      int               idx;
      win   = ptr;
      found = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NSRC) idx = idx - NSRC;
         if (!found && req[idx]) begin
            win   = PTR_W'(idx);
            found = 1'b1;
         end
      end
      return win;
   endfunction

   function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] p);
      return (int'(p) == NSRC - 1) ? '0 : p + 1'b1;
   endfunction

   // ---------------------------------------------------------------- state
   wr_state_t             wr_state_q, wr_state_d;
   rd_state_t             rd_state_q, rd_state_d;
   logic [AXI_ID_W-1:0]   wr_id_q, wr_id_d;
   logic [AXI_ID_W-1:0]   rd_id_q, rd_id_d;
   logic [7:0]            rd_len_q, rd_len_d;
   logic [7:0]            rd_cnt_q, rd_cnt_d;
   logic [SLV_NB:0]       fifo_mem_q [DEPTH];
   logic [SLV_NB:0]       fifo_mem_d [DEPTH];
   logic [L:0]            wr_ptr_q, wr_ptr_d;
   logic [L:0]            rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      b_ptr_q, b_ptr_d;
   logic [PTR_W-1:0]      r_ptr_q, r_ptr_d;
   logic                  r_lock_q, r_lock_d;
   logic [PTR_W-1:0]      r_lock_idx_q, r_lock_idx_d;

   // ---------------------------------------------------------------- wires
   logic [SLV_NB:0]       aw_sel, ar_sel, fifo_head;
   logic                  fifo_empty, fifo_full;
   logic                  aw_hs, ar_hs, w_hs, w_pop;
   logic                  err_wready, err_bvalid, err_rvalid, err_rlast;
   logic                  err_b_hs, err_r_hs, b_hs, r_hs;
   logic [NSRC-1:0]       b_req, r_req;
   logic [PTR_W-1:0]      b_win, r_win;
   logic [BCH_W-1:0]      b_ch [NSRC];
   logic [RCH_W-1:0]      r_ch [NSRC];
   logic [NSRC-1:0]       r_last;

   // ---------------------------------------------------------------- AW
   assign aw_sel        = decode(bus.i_awch[AXI_ADDR_W-1:0]);
   assign bus.o_awch    = {SLV_NB{bus.i_awch}};
   assign bus.o_awvalid = (bus.i_awvalid && !fifo_full) ? aw_sel[SLV_NB-1:0] : '0;
   assign bus.i_awready = !fifo_full &&
                          (aw_sel[ERR] ? (wr_state_q == WR_IDLE)
                                       : |(aw_sel[SLV_NB-1:0] & bus.o_awready));
   assign aw_hs         = bus.i_awvalid && bus.i_awready;

   // ---------------------------------------------------------------- AR
   assign ar_sel        = decode(bus.i_arch[AXI_ADDR_W-1:0]);
   assign bus.o_arch    = {SLV_NB{bus.i_arch}};
   assign bus.o_arvalid = bus.i_arvalid ? ar_sel[SLV_NB-1:0] : '0;
   assign bus.i_arready = ar_sel[ERR] ? (rd_state_q == RD_IDLE)
                                      : |(ar_sel[SLV_NB-1:0] & bus.o_arready);
   assign ar_hs         = bus.i_arvalid && bus.i_arready;

   // ---------------------------------------------------------------- W route
   // Registered FIFO: an entry is visible to W only the cycle after its push.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[L] != rd_ptr_q[L]) && (wr_ptr_q[L-1:0] == rd_ptr_q[L-1:0]);
   assign fifo_head  = fifo_mem_q[rd_ptr_q[L-1:0]];

   assign bus.o_wch    = {SLV_NB{bus.i_wch}};
   assign bus.o_wlast  = {SLV_NB{bus.i_wlast}};
   assign bus.o_wvalid = (bus.i_wvalid && !fifo_empty) ? fifo_head[SLV_NB-1:0] : '0;
   assign bus.i_wready = !fifo_empty &&
                         (fifo_head[ERR] ? err_wready
                                         : |(fifo_head[SLV_NB-1:0] & bus.o_wready));
   assign w_hs  = bus.i_wvalid && bus.i_wready;
   assign w_pop = w_hs && bus.i_wlast;

   always_comb begin
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (aw_hs) begin
         fifo_mem_d[wr_ptr_q[L-1:0]] = aw_sel;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_pop) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // ---------------------------------------------------------------- ERR write FSM
   always_comb begin
      wr_state_d = wr_state_q;
      case (wr_state_q)
         WR_IDLE: if (aw_hs && aw_sel[ERR])    wr_state_d = WR_DATA;
         WR_DATA: if (w_pop && fifo_head[ERR]) wr_state_d = WR_RESP;
         WR_RESP: if (err_b_hs)                wr_state_d = WR_IDLE;
         default:                              wr_state_d = WR_IDLE;
      endcase
   end

   always_comb begin
      err_wready = (wr_state_q == WR_DATA);
      err_bvalid = (wr_state_q == WR_RESP);
      wr_id_d    = (aw_hs && aw_sel[ERR]) ? bus.i_awch[ID_LSB +: AXI_ID_W] : wr_id_q;
   end

   // ---------------------------------------------------------------- ERR read FSM
   always_comb begin
      rd_state_d = rd_state_q;
      case (rd_state_q)
         RD_IDLE: if (ar_hs && ar_sel[ERR])  rd_state_d = RD_DATA;
         RD_DATA: if (err_r_hs && err_rlast) rd_state_d = RD_IDLE;
         default:                            rd_state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      err_rvalid = (rd_state_q == RD_DATA);
      err_rlast  = (rd_cnt_q == rd_len_q);
      rd_id_d    = rd_id_q;
      rd_len_d   = rd_len_q;
      rd_cnt_d   = rd_cnt_q;
      if (rd_state_q == RD_IDLE && ar_hs && ar_sel[ERR]) begin
         rd_id_d  = bus.i_arch[ID_LSB +: AXI_ID_W];
         rd_len_d = bus.i_arch[LEN_LSB +: 8];
         rd_cnt_d = '0;
      end else if (err_r_hs) begin
         rd_cnt_d = rd_cnt_q + 8'd1;
      end
   end

   // ---------------------------------------------------------------- B arbiter
   assign b_req = {err_bvalid, bus.o_bvalid};
   assign b_win = rr_pick(b_req, b_ptr_q);

   always_comb begin
      for (int k = 0; k < SLV_NB; k++) b_ch[k] = bus.o_bch[k*BCH_W +: BCH_W];
      b_ch[ERR] = {2'b11, wr_id_q};
   end

   assign bus.i_bvalid = |b_req;
   assign bus.i_bch    = b_ch[b_win];
   assign b_hs         = bus.i_bvalid && bus.i_bready;
   assign err_b_hs     = b_hs && (b_win == PTR_W'(ERR));

   always_comb begin
      bus.o_bready = '0;
      for (int k = 0; k < SLV_NB; k++)
         bus.o_bready[k] = bus.i_bready && b_req[k] && (b_win == PTR_W'(k));
   end

   assign b_ptr_d = b_hs ? next_idx(b_win) : b_ptr_q;

   // ---------------------------------------------------------------- R arbiter
   // A burst keeps the grant from its first beat until its rlast transfer.
   assign r_req = {err_rvalid, bus.o_rvalid};
   assign r_win = r_lock_q ? r_lock_idx_q : rr_pick(r_req, r_ptr_q);

   always_comb begin
      for (int k = 0; k < SLV_NB; k++) begin
         r_ch[k]   = bus.o_rch[k*RCH_W +: RCH_W];
         r_last[k] = bus.o_rlast[k];
      end
      r_ch[ERR]   = {2'b11, rd_id_q, {AXI_DATA_W{1'b0}}};
      r_last[ERR] = err_rlast;
   end

   assign bus.i_rvalid = r_req[r_win];
   assign bus.i_rch    = r_ch[r_win];
   assign bus.i_rlast  = r_last[r_win];
   assign r_hs         = bus.i_rvalid && bus.i_rready;
   assign err_r_hs     = r_hs && (r_win == PTR_W'(ERR));

   always_comb begin
      bus.o_rready = '0;
      for (int k = 0; k < SLV_NB; k++)
         bus.o_rready[k] = bus.i_rready && r_req[k] && (r_win == PTR_W'(k));
   end

   always_comb begin
      r_ptr_d      = r_ptr_q;
      r_lock_d     = r_lock_q;
      r_lock_idx_d = r_lock_idx_q;
      if (r_hs) begin
         if (bus.i_rlast) begin
            r_lock_d = 1'b0;
            r_ptr_d  = next_idx(r_win);
         end else begin
            r_lock_d     = 1'b1;
            r_lock_idx_d = r_win;
         end
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         wr_state_q <= WR_IDLE;
         rd_state_q <= RD_IDLE;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
      end
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         wr_id_q      <= '0;
         rd_id_q      <= '0;
         rd_len_q     <= '0;
         rd_cnt_q     <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         b_ptr_q      <= '0;
         r_ptr_q      <= '0;
         r_lock_q     <= 1'b0;
         r_lock_idx_q <= '0;
         for (int i = 0; i < DEPTH; i++) fifo_mem_q[i] <= '0;
      end else begin
         wr_id_q      <= wr_id_d;
         rd_id_q      <= rd_id_d;
         rd_len_q     <= rd_len_d;
         rd_cnt_q     <= rd_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         b_ptr_q      <= b_ptr_d;
         r_ptr_q      <= r_ptr_d;
         r_lock_q     <= r_lock_d;
         r_lock_idx_q <= r_lock_idx_d;
         for (int i = 0; i < DEPTH; i++) fifo_mem_q[i] <= fifo_mem_d[i];
      end
   end

   assign dbg_wr_state    = wr_state_q;
   assign dbg_rd_state    = rd_state_q;
   assign dbg_wfifo_empty = fifo_empty;

endmodule

// File: tb/tb_axicb_slv_switch.sv
// -----------------------------------------------------------------------------
// tb_axicb_slv_switch
// Directed bench for the slave switch: decoded write to slave 1, unmapped
// write and reads answered with DECERR, locked round-robin R arbitration,
// W-route FIFO full back-pressure and reset during an error read burst.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_axicb_slv_switch;
   localparam int SLV_NB = 4;
   localparam int AWCH_W = 32;
   localparam int WCH_W  = 8;
   localparam int BCH_W  = 10;
   localparam int ARCH_W = 32;
   localparam int RCH_W  = 18;

   logic       aclk = 1'b0;
   logic       arst;
   logic [1:0] dbg_wr_state;
   logic       dbg_rd_state;
   logic       dbg_wfifo_empty;
   int         checks   = 0;
   int         failures = 0;

   always #5 aclk = ~aclk;

   axicb_slv_switch_if #(
      .SLV_NB(SLV_NB), .AWCH_W(AWCH_W), .WCH_W(WCH_W),
      .BCH_W(BCH_W), .ARCH_W(ARCH_W), .RCH_W(RCH_W)
   ) bus ();

   axicb_slv_switch dut (
      .aclk            (aclk),
      .arst            (arst),
      .bus             (bus),
      .dbg_wr_state    (dbg_wr_state),
      .dbg_rd_state    (dbg_rd_state),
      .dbg_wfifo_empty (dbg_wfifo_empty)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [31:0] ax(input logic [15:0] a, input logic [7:0] id,
                                      input logic [7:0] len);
      return {len, id, a};
   endfunction

   initial begin
      arst = 1'b1;
      bus.i_awvalid = 0; bus.i_awch = '0;
      bus.i_wvalid = 0; bus.i_wlast = 0; bus.i_wch = '0;
      bus.i_bready = 0;
      bus.i_arvalid = 0; bus.i_arch = '0;
      bus.i_rready = 0;
      bus.o_awready = '0; bus.o_wready = '0;
      bus.o_bvalid = '0; bus.o_bch = '0;
      bus.o_arready = '0;
      bus.o_rvalid = '0; bus.o_rlast = '0; bus.o_rch = '0;

      // ---------------- reset state
      tick; tick;
      chk("rst_bvalid", bus.i_bvalid, 0);
      chk("rst_rvalid", bus.i_rvalid, 0);
      chk("rst_wready", bus.i_wready, 0);
      chk("rst_o_wvalid", bus.o_wvalid, 0);
      chk("rst_o_bready", bus.o_bready, 0);
      chk("rst_o_rready", bus.o_rready, 0);
      chk("rst_wr_state", dbg_wr_state, 0);
      chk("rst_rd_state", dbg_rd_state, 0);
      chk("rst_fifo_empty", dbg_wfifo_empty, 1);
      chk("rst_awready_low", bus.i_awready, 0);
      bus.o_awready = 4'hF; bus.o_arready = 4'hF; bus.o_wready = 4'hF;
      #1;
      chk("rst_awready_follow", bus.i_awready, 1);
      arst = 1'b0;
      tick;

      // ---------------- write 0x1004 LEN=3 ID=0x12 -> slave 1
      bus.i_awvalid = 1; bus.i_awch = ax(16'h1004, 8'h12, 8'd3);
      bus.i_wvalid = 1; bus.i_wch = 8'hA0; bus.i_wlast = 0;
      #1;
      chk("t1_awvalid", bus.o_awvalid, 4'b0010);
      chk("t1_awready", bus.i_awready, 1);
      chk("t1_awch_bcast", bus.o_awch, {4{ax(16'h1004, 8'h12, 8'd3)}});
      chk("t1_w_early_valid", bus.o_wvalid, 0);
      chk("t1_w_early_ready", bus.i_wready, 0);
      tick;
      bus.i_awvalid = 0;
      for (int b = 0; b < 4; b++) begin
         bus.i_wch = 8'(8'hA0 + b); bus.i_wlast = (b == 3);
         #1;
         chk("t1_wvalid", bus.o_wvalid, 4'b0010);
         chk("t1_wready", bus.i_wready, 1);
         chk("t1_wch", bus.o_wch[15:8], 8'(8'hA0 + b));
         tick;
      end
      bus.i_wvalid = 0; bus.i_wlast = 0;
      #1;
      chk("t1_fifo_empty", dbg_wfifo_empty, 1);
      bus.o_bvalid = 4'b0010; bus.o_bch[19:10] = {2'b00, 8'h12}; bus.i_bready = 1;
      #1;
      chk("t1_bvalid", bus.i_bvalid, 1);
      chk("t1_bch", bus.i_bch, 10'h012);
      chk("t1_bready", bus.o_bready, 4'b0010);
      tick;
      bus.o_bvalid = '0;

      // ---------------- write 0x9000 (unmapped) LEN=1 ID=0x05
      bus.i_awvalid = 1; bus.i_awch = ax(16'h9000, 8'h05, 8'd1);
      bus.i_wvalid = 1; bus.i_wch = 8'hB0; bus.i_wlast = 0;
      #1;
      chk("t2_awvalid_none", bus.o_awvalid, 0);
      chk("t2_awready", bus.i_awready, 1);
      chk("t2_wready_early", bus.i_wready, 0);
      tick;
      bus.i_awvalid = 0;
      #1;
      chk("t2_wr_state_data", dbg_wr_state, 1);
      chk("t2_o_wvalid_none", bus.o_wvalid, 0);
      chk("t2_wready_b0", bus.i_wready, 1);
      tick;
      bus.i_wch = 8'hB1; bus.i_wlast = 1;
      #1;
      chk("t2_wready_b1", bus.i_wready, 1);
      chk("t2_bvalid_early", bus.i_bvalid, 0);
      tick;
      bus.i_wvalid = 0; bus.i_wlast = 0;
      #1;
      chk("t2_bvalid", bus.i_bvalid, 1);
      chk("t2_bch", bus.i_bch, 10'h305);
      chk("t2_o_bready_none", bus.o_bready, 0);
      chk("t2_wr_state_resp", dbg_wr_state, 2);
      tick;
      chk("t2_bvalid_done", bus.i_bvalid, 0);
      chk("t2_wr_state_idle", dbg_wr_state, 0);
      bus.i_bready = 0;

      // ---------------- read 0xF000 LEN=7 ID=0x33, second unmapped AR stalls
      bus.i_rready = 1;
      bus.i_arvalid = 1; bus.i_arch = ax(16'hF000, 8'h33, 8'd7);
      #1;
      chk("t3_arvalid_none", bus.o_arvalid, 0);
      chk("t3_arready", bus.i_arready, 1);
      chk("t3_rvalid_early", bus.i_rvalid, 0);
      tick;
      bus.i_arch = ax(16'hE000, 8'h44, 8'd0);
      for (int b = 0; b < 8; b++) begin
         #1;
         chk("t3_rvalid", bus.i_rvalid, 1);
         chk("t3_rch", bus.i_rch, 18'h33300);
         chk("t3_rlast", bus.i_rlast, (b == 7));
         chk("t3_ar2_stall", bus.i_arready, 0);
         tick;
      end
      chk("t3_rd_idle", dbg_rd_state, 0);
      chk("t3_rvalid_gap", bus.i_rvalid, 0);
      chk("t3_ar2_ready", bus.i_arready, 1);
      tick;
      bus.i_arvalid = 0;
      #1;
      chk("t3_r2_valid", bus.i_rvalid, 1);
      chk("t3_r2_rch", bus.i_rch, 18'h34400);
      chk("t3_r2_rlast", bus.i_rlast, 1);
      tick;
      chk("t3_r2_done", bus.i_rvalid, 0);

      // ---------------- slaves 0 and 2 start 4-beat R bursts together
      bus.o_rvalid = 4'b0101;
      bus.o_rch[2*RCH_W +: RCH_W] = 18'h02000;
      for (int b = 0; b < 4; b++) begin
         bus.o_rch[0 +: RCH_W] = 18'(18'h01000 + b);
         bus.o_rlast[0] = (b == 3);
         #1;
         chk("t4_s0_grant", bus.o_rready, 4'b0001);
         chk("t4_s0_rch", bus.i_rch, 18'(18'h01000 + b));
         chk("t4_s0_rlast", bus.i_rlast, (b == 3));
         tick;
      end
      bus.o_rvalid[0] = 0; bus.o_rlast[0] = 0;
      for (int b = 0; b < 4; b++) begin
         bus.o_rch[2*RCH_W +: RCH_W] = 18'(18'h02000 + b);
         bus.o_rlast[2] = (b == 3);
         if (b == 1) begin
            // slave 1 competes mid-burst; the lock must hold slave 2
            bus.o_rvalid[1] = 1;
            bus.o_rch[1*RCH_W +: RCH_W] = 18'h01100;
            bus.o_rlast[1] = 1;
         end
         #1;
         chk("t4_s2_grant", bus.o_rready, 4'b0100);
         chk("t4_s2_rch", bus.i_rch, 18'(18'h02000 + b));
         tick;
      end
      bus.o_rvalid[2] = 0; bus.o_rlast[2] = 0;
      bus.o_rvalid[0] = 1; bus.o_rch[0 +: RCH_W] = 18'h01055; bus.o_rlast[0] = 1;
      #1;
      chk("t4_wrap_s0", bus.o_rready, 4'b0001);
      chk("t4_wrap_s0_rch", bus.i_rch, 18'h01055);
      tick;
      bus.o_rvalid[0] = 0; bus.o_rlast[0] = 0;
      #1;
      chk("t4_then_s1", bus.o_rready, 4'b0010);
      chk("t4_s1_rch", bus.i_rch, 18'h01100);
      chk("t4_s1_rlast", bus.i_rlast, 1);
      tick;
      bus.o_rvalid = '0; bus.o_rlast = '0;

      // ---------------- 9 AWs to slave 3 with wready low
      bus.o_wready = '0;
      bus.i_awvalid = 1; bus.i_awch = ax(16'h3000, 8'h77, 8'd0);
      bus.i_wvalid = 1; bus.i_wch = 8'hC0; bus.i_wlast = 1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("t5_aw_accept", bus.i_awready, 1);
         chk("t5_awvalid", bus.o_awvalid, 4'b1000);
         tick;
      end
      chk("t5_full_awready", bus.i_awready, 0);
      chk("t5_full_awvalid", bus.o_awvalid, 0);
      chk("t5_wvalid_s3", bus.o_wvalid, 4'b1000);
      chk("t5_wready_low", bus.i_wready, 0);
      tick;
      chk("t5_full_hold", bus.i_awready, 0);
      bus.o_wready = 4'b1000;
      #1;
      chk("t5_wready_pop", bus.i_wready, 1);
      chk("t5_full_on_pop", bus.i_awready, 0);
      tick;
      chk("t5_aw9_accept", bus.i_awready, 1);
      tick;
      bus.i_awvalid = 0;
      for (int i = 0; i < 7; i++) begin
         #1;
         chk("t5_drain", bus.i_wready, 1);
         tick;
      end
      bus.i_wvalid = 0; bus.i_wlast = 0;
      #1;
      chk("t5_fifo_empty", dbg_wfifo_empty, 1);

      // ---------------- reset during ERR read beat 3
      bus.i_awvalid = 1; bus.i_awch = ax(16'h0010, 8'h01, 8'd0);
      #1;
      chk("t6_aw_accept", bus.i_awready, 1);
      tick;
      bus.i_awvalid = 0;
      #1;
      chk("t6_fifo_nonempty", dbg_wfifo_empty, 0);
      bus.i_arvalid = 1; bus.i_arch = ax(16'hF000, 8'h55, 8'd7);
      tick;
      bus.i_arvalid = 0;
      for (int b = 0; b < 3; b++) begin
         #1;
         chk("t6_rch", bus.i_rch, 18'h35500);
         tick;
      end
      chk("t6_beat3_valid", bus.i_rvalid, 1);
      arst = 1'b1;
      #1;
      chk("t6_rst_rvalid", bus.i_rvalid, 0);
      chk("t6_rst_rd_state", dbg_rd_state, 0);
      chk("t6_rst_fifo", dbg_wfifo_empty, 1);
      bus.i_wvalid = 1;
      #1;
      chk("t6_rst_wready", bus.i_wready, 0);
      chk("t6_rst_o_wvalid", bus.o_wvalid, 0);
      tick;
      arst = 1'b0;
      bus.i_wvalid = 0;
      tick;
      chk("t6_post_rvalid", bus.i_rvalid, 0);
      chk("t6_post_fifo", dbg_wfifo_empty, 1);
      chk("t6_post_wr_state", dbg_wr_state, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
